// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

  localparam int MULT_W = 32;
  localparam int CNT_W  = $clog2(MULT_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/neg_abs.sv
// Conditional two's-complement negate: out = en ? -in : in.
module neg_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         en,
  output logic [W-1:0] out
);

  // Negation of the most negative value wraps to itself, which is exactly
  // its unsigned magnitude, so no special case is needed.
  always_comb begin
    out = en ? (~in + W'(1)) : in;
  end

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle radix-2 shift-add multiplier (MULT / MULTU).
// Operands are reduced to magnitudes on accept, multiplied unsigned over
// WIDTH cycles, then the sign is applied in a single fix-up cycle.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand_sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic               busy_nx;
  logic               done_nx;

  neg_abs #(.W(WIDTH)) u_abs_a (
    .in  (a),
    .en  (is_signed & a[WIDTH-1]),
    .out (mag_a)
  );

  neg_abs #(.W(WIDTH)) u_abs_b (
    .in  (b),
    .en  (is_signed & b[WIDTH-1]),
    .out (mag_b)
  );

  neg_abs #(.W(2*WIDTH)) u_fix (
    .in  (acc),
    .en  (neg),
    .out (prod)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: start is only honoured in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode; busy/done are registered from these values
  always_comb begin
    busy_nx = (state_nx == CALC) || (state_nx == FIX);
    done_nx = (state == FIX);
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
    end
  end

  // Datapath: the multiplicand shifts left each step instead of being
  // shifted by cnt, which is the same partial-product sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_sh <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand_sh <= {{WIDTH{1'b0}}, mag_a};
            mplier   <= mag_b;
            neg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand_sh;
          mcand_sh <= mcand_sh << 1;
          mplier   <= mplier >> 1;
          cnt      <= cnt + CW'(1);
        end
        FIX: begin
          result <= prod;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner cases, protocol
// behaviour (ignored start, async reset, back-to-back) and random operands
// checked against a plain-arithmetic product model.
module tb_mult_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks;
  int failures;

  mult_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product from ordinary integer arithmetic
  function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic        s);
    longint sx, sy;
    logic [63:0] ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // One full operation; operands are scrambled while busy, and optionally a
  // spurious start with fresh operands is pulsed at busy cycle inject_at.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                        input logic xs, input logic [63:0] exp,
                        input string tag, input int inject_at);
    int cyc;
    int bcnt;
    @(negedge clk);
    a = xa; b = xb; is_signed = xs; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 100) begin
      if (busy) bcnt++;
      a = $urandom;
      b = $urandom;
      is_signed = 1'($urandom_range(0, 1));
      start = (cyc == inject_at);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, 64'(done), 64'd1);
    chk({tag, ".busy_cycles"}, 64'(bcnt), 64'd33);
    chk({tag, ".busy_in_done"}, 64'(busy), 64'd0);
    chk({tag, ".result"}, result, exp);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic        rs;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;

    #12;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed products
    run_op(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, "u7x6", -1);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "sm3x5", -1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "smin2", -1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax2", -1);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 64'd0, "szero", -1);

    // Spurious start mid-operation must not re-latch or add a done
    run_op(32'd1234, 32'd567, 1'b0, 64'd699678, "inject", 10);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("inject.extra_done", 64'(n), 64'd0);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    a = 32'd1000; b = 32'd1000; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    chk("arst.result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("arst.no_activity", 64'(n), 64'd0);
    run_op(32'd5, 32'd5, 1'b0, 64'd25, "after_rst", -1);

    // Start held through the done cycle: second op accepted there
    @(negedge clk);
    a = 32'd2; b = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 32'd4; b = 32'd5;
    n = 0;
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b2b.first_done", 64'(done), 64'd1);
    chk("b2b.first_result", result, 64'd6);
    @(negedge clk);
    start = 1'b0;
    chk("b2b.accepted", 64'(busy), 64'd1);
    n = 1;
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("b2b.second_done", 64'(done), 64'd1);
    chk("b2b.second_result", result, 64'd20);
    chk("b2b.done_spacing", 64'(n), 64'd34);

    // Random operands, with some bias towards sign-bit and extreme values
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, ref_mul(ra, rb, rs), "rand", -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
